operand_fetch_stage: RTL and testbench

//  Parametrised successor of the decode/operand-read stage. Reads N_SRC source

---
 rtl/operand_fetch_stage_if.sv | 50 +++++
 rtl/operand_fetch_stage.sv | 122 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_stage_if.sv
// Operand-fetch bus: micro-op in, forwarding/GPR view, flush, resolved micro-op out.
interface operand_fetch_stage_if #(
  parameter int unsigned REG_W = 64,
  parameter int unsigned REG_N = 16,
  parameter int unsigned N_SRC = 3,
  parameter int unsigned LD    = 3,
  parameter int unsigned OP_W  = 8,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned IDX_W = $clog2(REG_N + 1);

  // upstream micro-op handshake
  logic                   in_valid;
  logic                   in_ready;
  logic [OP_W-1:0]        in_op;
  logic [REG_W-1:0]       in_pc;
  logic [N_SRC*IDX_W-1:0] in_src_idx;

  // register file and forwarding layers
  logic [REG_N*REG_W-1:0] gpr;
  logic [LD-1:0]          fwd_en;
  logic [LD*IDX_W-1:0]    fwd_idx;
  logic [LD-1:0]          fwd_pend;
  logic [LD*REG_W-1:0]    fwd_val;
  logic                   flush;

  // downstream micro-op handshake
  logic                   out_valid;
  logic                   out_ready;
  logic [OP_W-1:0]        out_op;
  logic [REG_W-1:0]       out_pc;
  logic [N_SRC*REG_W-1:0] out_src_val;
  logic [CNT_W-1:0]       stall_cnt;

  // environment side: queue head, register file, forwarding network, execute stage
  modport master (
    output in_valid, in_op, in_pc, in_src_idx,
    output gpr, fwd_en, fwd_idx, fwd_pend, fwd_val, flush,
    output out_ready,
    input  in_ready, out_valid, out_op, out_pc, out_src_val, stall_cnt
  );

  // stage side
  modport slave (
    input  in_valid, in_op, in_pc, in_src_idx,
    input  gpr, fwd_en, fwd_idx, fwd_pend, fwd_val, flush,
    input  out_ready,
    output in_ready, out_valid, out_op, out_pc, out_src_val, stall_cnt
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads N_SRC operands from the GPR file, overrides them with the
// nearest forwarding layer, interlocks on pending results and registers the
// resolved micro-op towards execute.
module operand_fetch_stage #(
  parameter int unsigned REG_W   = 64,
  parameter int unsigned REG_N   = 16,
  parameter int unsigned N_SRC   = 3,
  parameter int unsigned LD      = 3,
  parameter int unsigned RIP_IDX = 16,
  parameter int unsigned PC_INC  = 1,
  parameter int unsigned OP_W    = 8,
  parameter int unsigned CNT_W   = 16
) (
  input logic                  clk,
  input logic                  rstn,
  operand_fetch_stage_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(REG_N + 1);

  // RIP must not alias a real register
  if (RIP_IDX < REG_N) begin : g_bad_rip
    $error("RIP_IDX must be >= REG_N");
  end

  logic [N_SRC*REG_W-1:0] src_val;
  logic                   hazard;
  logic                   in_ready;
  logic                   accept;

  logic [IDX_W-1:0]       cur_idx;
  logic [REG_W-1:0]       cur_val;
  logic                   cur_hit;
  logic                   cur_pend;

  logic                   out_valid_q;
  logic [OP_W-1:0]        out_op_q;
  logic [REG_W-1:0]       out_pc_q;
  logic [N_SRC*REG_W-1:0] out_src_val_q;
  logic [CNT_W-1:0]       stall_cnt_q;

  // Per-channel operand resolution: RIP, else nearest enabled layer, else GPR (0 if out of range)
  always_comb begin
    src_val  = '0;
    hazard   = 1'b0;
    cur_idx  = '0;
    cur_val  = '0;
    cur_hit  = 1'b0;
    cur_pend = 1'b0;
    for (int c = 0; c < int'(N_SRC); c++) begin
      cur_idx  = bus.in_src_idx[c*IDX_W +: IDX_W];
      cur_val  = '0;
      cur_hit  = 1'b0;
      cur_pend = 1'b0;
      if (cur_idx == IDX_W'(RIP_IDX)) begin
        cur_val = bus.in_pc + REG_W'(PC_INC);
      end else begin
        for (int l = 0; l < int'(LD); l++) begin
          if (!cur_hit && bus.fwd_en[l] && (bus.fwd_idx[l*IDX_W +: IDX_W] == cur_idx)) begin
            cur_hit  = 1'b1;
            cur_val  = bus.fwd_val[l*REG_W +: REG_W];
            cur_pend = bus.fwd_pend[l];
          end
        end
        if (!cur_hit) begin
          for (int r = 0; r < int'(REG_N); r++) begin
            if (cur_idx == IDX_W'(r)) begin
              cur_val = bus.gpr[r*REG_W +: REG_W];
            end
          end
        end
      end
      src_val[c*REG_W +: REG_W] = cur_val;
      if (cur_pend) begin
        hazard = bus.in_valid;
      end
    end
  end

  // Handshake: accept only when not in reset, not flushing, no interlock and output can move
  always_comb begin
    in_ready = rstn & ~bus.flush & ~hazard & (~out_valid_q | bus.out_ready);
    accept   = bus.in_valid & in_ready;
  end

  // Output register: flush beats accept, accept beats drain, otherwise hold
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q   <= 1'b0;
      out_op_q      <= '0;
      out_pc_q      <= '0;
      out_src_val_q <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      out_op_q      <= bus.in_op;
      out_pc_q      <= bus.in_pc;
      out_src_val_q <= src_val;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
    end
  end

  // Saturating count of interlock cycles; flushed cycles are not counted
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else if (hazard && !bus.flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_op      = out_op_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_src_val = out_src_val_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with hand-computed expectations.
module tb_operand_fetch_stage;
  localparam int unsigned REG_W   = 64;
  localparam int unsigned REG_N   = 16;
  localparam int unsigned N_SRC   = 3;
  localparam int unsigned LD      = 3;
  localparam int unsigned RIP_IDX = 16;
  localparam int unsigned PC_INC  = 1;
  localparam int unsigned OP_W    = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned IDX_W   = 5;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  operand_fetch_stage_if #(
    .REG_W(REG_W), .REG_N(REG_N), .N_SRC(N_SRC), .LD(LD), .OP_W(OP_W), .CNT_W(CNT_W)
  ) bus ();

  operand_fetch_stage #(
    .REG_W(REG_W), .REG_N(REG_N), .N_SRC(N_SRC), .LD(LD), .RIP_IDX(RIP_IDX),
    .PC_INC(PC_INC), .OP_W(OP_W), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one observed value against its expectation
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] chan(input int c);
    return bus.out_src_val[c*REG_W +: REG_W];
  endfunction

  task automatic set_idx(input int d, input int s, input int t);
    bus.in_src_idx[0*IDX_W +: IDX_W] = IDX_W'(d);
    bus.in_src_idx[1*IDX_W +: IDX_W] = IDX_W'(s);
    bus.in_src_idx[2*IDX_W +: IDX_W] = IDX_W'(t);
  endtask

  task automatic set_fwd(input int l, input logic en, input int idx, input logic pend,
                         input logic [63:0] val);
    bus.fwd_en[l]                  = en;
    bus.fwd_idx[l*IDX_W +: IDX_W]  = IDX_W'(idx);
    bus.fwd_pend[l]                = pend;
    bus.fwd_val[l*REG_W +: REG_W]  = val;
  endtask

  task automatic clear_fwd();
    bus.fwd_en   = '0;
    bus.fwd_idx  = '0;
    bus.fwd_pend = '0;
    bus.fwd_val  = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_op"},    64'(bus.out_op),    64'd0);
    check({tag, "_pc"},    bus.out_pc,         64'd0);
    check({tag, "_d"},     chan(0),            64'd0);
    check({tag, "_s"},     chan(1),            64'd0);
    check({tag, "_t"},     chan(2),            64'd0);
    check({tag, "_cnt"},   64'(bus.stall_cnt), 64'd0);
    check({tag, "_rdy"},   64'(bus.in_ready),  64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_pc     = '0;
    bus.in_src_idx = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    clear_fwd();
    for (int r = 0; r < int'(REG_N); r++) bus.gpr[r*REG_W +: REG_W] = 64'(256 + r);
    bus.gpr[3*REG_W +: REG_W] = 64'h11;

    tick();
    tick();
    check_reset_state("rst");
    rstn = 1'b1;

    // T1: plain GPR read, one-cycle latency
    bus.in_valid = 1'b1; bus.in_op = 8'd1; bus.in_pc = 64'h40; bus.out_ready = 1'b1;
    set_idx(3, 3, 3);
    #1 check("t1_rdy", 64'(bus.in_ready), 64'd1);
    tick();
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_op", 64'(bus.out_op), 64'd1);
    check("t1_pc", bus.out_pc, 64'h40);
    check("t1_d", chan(0), 64'h11);
    check("t1_s", chan(1), 64'h11);
    check("t1_t", chan(2), 64'h11);

    // T2: layer 1 beats layer 2; disabled layer 0 ignored
    bus.in_op = 8'd2; bus.in_pc = 64'h50;
    set_idx(3, 5, 7);
    set_fwd(0, 1'b0, 5, 1'b0, 64'hC);
    set_fwd(1, 1'b1, 5, 1'b0, 64'hA);
    set_fwd(2, 1'b1, 5, 1'b0, 64'hB);
    tick();
    check("t2_valid", 64'(bus.out_valid), 64'd1);
    check("t2_op", 64'(bus.out_op), 64'd2);
    check("t2_d", chan(0), 64'h11);
    check("t2_s", chan(1), 64'hA);
    check("t2_t", chan(2), 64'h107);

    // T3: load-use interlock for 4 cycles, then release
    clear_fwd();
    set_fwd(0, 1'b1, 5, 1'b1, 64'hD);
    bus.in_op = 8'd3; bus.in_pc = 64'h60;
    set_idx(5, 5, 5);
    #1 check("t3_rdy_stall", 64'(bus.in_ready), 64'd0);
    repeat (4) tick();
    check("t3_cnt", 64'(bus.stall_cnt), 64'd4);
    check("t3_drained", 64'(bus.out_valid), 64'd0);
    check("t3_drained_op", 64'(bus.out_op), 64'd0);
    bus.fwd_pend[0] = 1'b0;
    #1 check("t3_rdy_go", 64'(bus.in_ready), 64'd1);
    tick();
    check("t3_op", 64'(bus.out_op), 64'd3);
    check("t3_d", chan(0), 64'hD);
    check("t3_t", chan(2), 64'hD);
    check("t3_cnt_hold", 64'(bus.stall_cnt), 64'd4);

    // T3b: farther pending match masked by nearer ready match
    set_fwd(0, 1'b1, 5, 1'b0, 64'hE);
    set_fwd(1, 1'b1, 5, 1'b1, 64'hF);
    #1 check("t3b_rdy", 64'(bus.in_ready), 64'd1);
    tick();
    check("t3b_s", chan(1), 64'hE);
    check("t3b_cnt", 64'(bus.stall_cnt), 64'd4);

    // T4: RIP operand wraps, forwarding on index 16 ignored; out-of-range index reads 0
    clear_fwd();
    set_fwd(0, 1'b1, 16, 1'b1, 64'h77);
    bus.in_op = 8'd4; bus.in_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    set_idx(16, 3, 20);
    #1 check("t4_rdy", 64'(bus.in_ready), 64'd1);
    tick();
    check("t4_d", chan(0), 64'd0);
    check("t4_s", chan(1), 64'h11);
    check("t4_t", chan(2), 64'd0);
    check("t4_pc", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFF);

    // T5: hold under backpressure, then simultaneous consume and accept
    clear_fwd();
    bus.out_ready = 1'b0;
    bus.in_op = 8'd5; bus.in_pc = 64'h70;
    set_idx(1, 2, 3);
    #1 check("t5_rdy_hold", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_hold_op", 64'(bus.out_op), 64'd4);
    end
    check("t5_hold_pc", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t5_hold_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    #1 check("t5_rdy_go", 64'(bus.in_ready), 64'd1);
    tick();
    check("t5_valid", 64'(bus.out_valid), 64'd1);
    check("t5_op", 64'(bus.out_op), 64'd5);
    check("t5_d", chan(0), 64'h101);
    check("t5_s", chan(1), 64'h102);
    bus.in_valid = 1'b0;
    tick();
    check("t5_drain_valid", 64'(bus.out_valid), 64'd0);
    check("t5_drain_op", 64'(bus.out_op), 64'd0);

    // T6: flush clears a held output; flushed hazard cycles are not counted
    bus.in_valid = 1'b1; bus.in_op = 8'd6;
    tick();
    check("t6_loaded", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    set_fwd(0, 1'b1, 1, 1'b1, 64'h1);
    #1 check("t6_rdy_flush", 64'(bus.in_ready), 64'd0);
    tick();
    check("t6_flush_valid", 64'(bus.out_valid), 64'd0);
    check("t6_flush_op", 64'(bus.out_op), 64'd0);
    check("t6_flush_cnt", 64'(bus.stall_cnt), 64'd4);
    bus.flush = 1'b0;

    // load op 7, then hold it while an interlock saturates the counter
    clear_fwd();
    bus.out_ready = 1'b1; bus.in_op = 8'd7;
    tick();
    bus.out_ready = 1'b0;
    set_fwd(0, 1'b1, 1, 1'b1, 64'h1);
    repeat (65530) @(posedge clk);
    #1 check("t6_cnt_near", 64'(bus.stall_cnt), 64'd65534);
    tick();
    check("t6_cnt_max", 64'(bus.stall_cnt), 64'd65535);
    repeat (3) tick();
    check("t6_cnt_sat", 64'(bus.stall_cnt), 64'd65535);
    check("t6_hold_op", 64'(bus.out_op), 64'd7);

    // reset mid-stall and mid-hold
    rstn = 1'b0;
    tick();
    check_reset_state("rst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
